// File: rtl/tdm_demux_1to4_pkg.sv
// Shared TDM link definitions: slot geometry and receiver state encoding.
// The state values match the encodings used on the mux/serialiser side.
package tdm_demux_1to4_pkg;

  localparam int unsigned TDM_NUM_SLOTS = 4;
  localparam int unsigned TDM_SLOT_W    = 2;

  typedef logic [TDM_SLOT_W-1:0] slot_t;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } tdm_state_e;

  localparam slot_t SLOT_FIRST = '0;
  localparam slot_t SLOT_ONE   = slot_t'(1);
  localparam slot_t SLOT_LAST  = slot_t'(TDM_NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_demux_1to4_slot_counter.sv
// Slot counter for the TDM receiver: enable-driven increment wrapping at the
// last slot, synchronous load (priority over enable), asynchronous reset.
module tdm_slot_counter
  import tdm_demux_1to4_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [TDM_SLOT_W-1:0] load_val,
  output logic [TDM_SLOT_W-1:0] count
);

  slot_t count_q;
  slot_t count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = (count_q == SLOT_LAST) ? SLOT_FIRST : count_q + SLOT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= SLOT_FIRST;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tdm_demux_1to4.sv
// Receive side of the 4:1 TDM link: aligns on frame_sync, collects slots 0..2
// in shadow registers and publishes all four lanes atomically on slot 3.
module tdm_demux_1to4
  import tdm_demux_1to4_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  input  logic                  frame_sync,
  output logic [WIDTH-1:0]      out0,
  output logic [WIDTH-1:0]      out1,
  output logic [WIDTH-1:0]      out2,
  output logic [WIDTH-1:0]      out3,
  output logic                  frame_valid,
  output logic [TDM_SLOT_W-1:0] slot_sel,
  output logic                  locked,
  output logic                  sync_err
);

  tdm_state_e       state_q, state_d;
  logic [WIDTH-1:0] shadow_q [3];
  logic [WIDTH-1:0] shadow_d [3];
  logic [WIDTH-1:0] out_q    [4];
  logic [WIDTH-1:0] out_d    [4];
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;

  slot_t slot;
  logic  cnt_en;
  logic  cnt_load;
  slot_t cnt_load_val;

  tdm_slot_counter u_slot_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (cnt_en),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .count    (slot)
  );

  // A frame_sync beat always restarts the frame at slot 0, whatever the state;
  // it only counts as an error when it interrupts a frame already in progress.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    cnt_en        = 1'b0;
    cnt_load      = 1'b0;
    cnt_load_val  = SLOT_FIRST;

    if (din_valid) begin
      if (frame_sync) begin
        shadow_d[0]  = din;
        cnt_load     = 1'b1;
        cnt_load_val = SLOT_ONE;
        state_d      = ST_LOCKED;
        if (state_q == ST_LOCKED && slot != SLOT_FIRST) begin
          sync_err_d = 1'b1;
        end
      end else if (state_q == ST_LOCKED) begin
        if (slot == SLOT_FIRST) begin
          sync_err_d   = 1'b1;
          state_d      = ST_HUNT;
          cnt_load     = 1'b1;
          cnt_load_val = SLOT_FIRST;
        end else if (slot == SLOT_LAST) begin
          out_d[0]      = shadow_q[0];
          out_d[1]      = shadow_q[1];
          out_d[2]      = shadow_q[2];
          out_d[3]      = din;
          frame_valid_d = 1'b1;
          cnt_en        = 1'b1;
        end else begin
          case (slot)
            2'd1:    shadow_d[1] = din;
            2'd2:    shadow_d[2] = din;
            default: ;
          endcase
          cnt_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      shadow_q      <= '{default: '0};
      out_q         <= '{default: '0};
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      out_q         <= out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign out0        = out_q[0];
  assign out1        = out_q[1];
  assign out2        = out_q[2];
  assign out3        = out_q[3];
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign slot_sel    = slot;
  assign locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Bench for tdm_demux_1to4: directed scenarios then random traffic, every
// cycle compared against a frame-assembly reference model.
module tb_tdm_demux_1to4;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] out0, out1, out2, out3;
  logic         frame_valid;
  logic [1:0]   slot_sel;
  logic         locked;
  logic         sync_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: beats collected for the current frame.
  int           m_pos = 0;
  bit           m_locked = 0;
  logic [W-1:0] m_coll[$];
  logic [W-1:0] m_out[4];
  bit           m_fv = 0;
  bit           m_err = 0;

  tdm_demux_1to4 #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .frame_valid (frame_valid),
    .slot_sel    (slot_sel),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_locked = 0;
    m_coll.delete();
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_fv = 0;
    m_err = 0;
  endtask

  task automatic model_beat(input logic v, input logic fs, input logic [W-1:0] d);
    m_fv = 0;
    m_err = 0;
    if (v) begin
      if (fs) begin
        if (m_locked && m_pos != 0) m_err = 1;
        m_coll.delete();
        m_coll.push_back(d);
        m_pos = 1;
        m_locked = 1;
      end else if (m_locked) begin
        if (m_pos == 0) begin
          m_err = 1;
          m_locked = 0;
        end else begin
          m_coll.push_back(d);
          m_pos++;
          if (m_pos == 4) begin
            for (int i = 0; i < 4; i++) m_out[i] = m_coll[i];
            m_fv = 1;
            m_pos = 0;
            m_coll.delete();
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out0"}, 32'(out0), 32'(m_out[0]));
    chk({tag, ".out1"}, 32'(out1), 32'(m_out[1]));
    chk({tag, ".out2"}, 32'(out2), 32'(m_out[2]));
    chk({tag, ".out3"}, 32'(out3), 32'(m_out[3]));
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    chk({tag, ".sync_err"}, 32'(sync_err), 32'(m_err));
    chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
    chk({tag, ".slot_sel"}, 32'(slot_sel), 32'(m_pos));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic beat(input string tag, input logic v, input logic fs, input logic [W-1:0] d);
    din_valid = v;
    frame_sync = fs;
    din = d;
    @(posedge clk);
    model_beat(v, fs, d);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // 1: first frame 1,0,1,1
    beat("t1b1", 1, 1, 4'h1);
    chk("t1_locked_after_b1", 32'(locked), 32'd1);
    beat("t1b2", 1, 0, 4'h0);
    beat("t1b3", 1, 0, 4'h1);
    beat("t1b4", 1, 0, 4'h1);
    chk("t1_fv", 32'(frame_valid), 32'd1);
    chk("t1_lanes", {16'd0, out0, out1, out2, out3}, 32'h1011);
    beat("t1_after", 0, 0, 4'h0);
    chk("t1_fv_pulse", 32'(frame_valid), 32'd0);

    // 2: three back-to-back frames
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 4; s++)
        beat("t2", 1, (s == 0), W'(4 * f + s + 3));
    chk("t2_last_lanes", {16'd0, out0, out1, out2, out3}, 32'hbcde);

    // 3: stall between beats 2 and 3
    beat("t3b1", 1, 1, 4'h9);
    beat("t3b2", 1, 0, 4'h8);
    for (int i = 0; i < 3; i++) beat("t3stall", 0, (i == 1), 4'hf);
    beat("t3b3", 1, 0, 4'h7);
    beat("t3b4", 1, 0, 4'h6);
    chk("t3_lanes", {16'd0, out0, out1, out2, out3}, 32'h9876);

    // 4: frame_sync arriving at slot 2
    beat("t4b1", 1, 1, 4'h1);
    beat("t4b2", 1, 0, 4'h2);
    beat("t4sync", 1, 1, 4'ha);
    chk("t4_err", 32'(sync_err), 32'd1);
    beat("t4b2r", 1, 0, 4'hb);
    beat("t4b3r", 1, 0, 4'hc);
    beat("t4b4r", 1, 0, 4'hd);
    chk("t4_lanes", {16'd0, out0, out1, out2, out3}, 32'habcd);

    // 5: missing frame_sync at slot 0, then relock
    beat("t5miss", 1, 0, 4'h3);
    chk("t5_unlocked", 32'(locked), 32'd0);
    for (int i = 0; i < 5; i++) beat("t5hunt", 1, 0, W'(i));
    for (int s = 0; s < 4; s++) beat("t5relock", 1, (s == 0), W'(s + 2));
    chk("t5_lanes", {16'd0, out0, out1, out2, out3}, 32'h2345);

    // 6: asynchronous reset mid-frame
    beat("t6b1", 1, 1, 4'he);
    beat("t6b2", 1, 0, 4'hf);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t6async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) beat("t6nosync", 1, 0, W'(i + 1));

    // Random traffic with occasional misplaced or missing frame_sync
    for (int i = 0; i < 400; i++) begin
      logic v, fs;
      v = ($urandom_range(3) != 0);
      fs = (m_pos == 0) ^ ($urandom_range(9) == 0);
      beat("rand", v, fs, W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
